// File: rtl/logic_arb_pkg.sv
// Shared state enum, opcodes and default sizes for logic_unit_arbiter.
// Opcodes matter only when LOGIC_ARB_OPSEL_EN is defined.
package logic_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;

endpackage

// File: rtl/logic_unit_arbiter_bitwise.sv
// Combinational WIDTH-bit logic unit (bitwise_unit).
// LOGIC_ARB_OPSEL_EN adds the op select; otherwise AND only.
module bitwise_unit
  import logic_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef LOGIC_ARB_OPSEL_EN
  input  logic [1:0]       op,
`endif
  output logic [WIDTH-1:0] y
);

`ifdef LOGIC_ARB_OPSEL_EN
  always_comb begin
    y = a & b;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      default: y = a & b;
    endcase
  end
`else
  assign y = a & b;
`endif

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one registered bitwise unit among NREQ requesters.
// Define LOGIC_ARB_OPSEL_EN to add the req_op port and 4-op datapath.
module logic_unit_arbiter
  import logic_arb_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef LOGIC_ARB_OPSEL_EN
  input  logic [NREQ*2-1:0]     req_op,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] alu_y;
  logic [IDW-1:0]   grant_idx;
  logic             grant_vld;
`ifdef LOGIC_ARB_OPSEL_EN
  logic [1:0]       op_q, op_d;
`endif

  // first valid requester at or after ptr, wrapping
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!grant_vld && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        grant_vld = 1'b1;
        grant_idx = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  bitwise_unit #(.WIDTH(WIDTH)) u_alu (
    .a  (a_q),
    .b  (b_q),
`ifdef LOGIC_ARB_OPSEL_EN
    .op (op_q),
`endif
    .y  (alu_y)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    req_ready = '0;
`ifdef LOGIC_ARB_OPSEL_EN
    op_d      = op_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_vld && rst_n) begin
          req_ready[grant_idx] = 1'b1;
          a_d     = req_a[int'(grant_idx)*WIDTH +: WIDTH];
          b_d     = req_b[int'(grant_idx)*WIDTH +: WIDTH];
`ifdef LOGIC_ARB_OPSEL_EN
          op_d    = req_op[int'(grant_idx)*2 +: 2];
`endif
          id_d    = grant_idx;
          state_d = EXEC;
        end
      end
      EXEC: begin
        data_d  = alu_y;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
`ifdef LOGIC_ARB_OPSEL_EN
      op_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
`ifdef LOGIC_ARB_OPSEL_EN
      op_q    <= op_d;
`endif
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Self-checking bench for logic_unit_arbiter with a transaction-level
// round-robin reference model; honours LOGIC_ARB_OPSEL_EN.
module tb_logic_unit_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  vld = '0;
  logic [3:0]  req_ready;
  logic [15:0] a_bus, b_bus;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [3:0]  ra [4];
  logic [3:0]  rb [4];
  logic [1:0]  ro [4];
`ifdef LOGIC_ARB_OPSEL_EN
  logic [7:0]  op_bus;
`endif

  int checks = 0;
  int failures = 0;
  int mptr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign a_bus[g*4 +: 4] = ra[g];
    assign b_bus[g*4 +: 4] = rb[g];
`ifdef LOGIC_ARB_OPSEL_EN
    assign op_bus[g*2 +: 2] = ro[g];
`endif
  end

  logic_unit_arbiter #(.NREQ(4), .WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (vld),
    .req_ready (req_ready),
    .req_a     (a_bus),
    .req_b     (b_bus),
`ifdef LOGIC_ARB_OPSEL_EN
    .req_op    (op_bus),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  function automatic int rr_pick(input logic [3:0] m, input int p);
    for (int k = 0; k < 4; k++)
      if (m[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] ref_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op);
    case (op)
      2'd0: return a & b;
      2'd1: return a | b;
      2'd2: return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

  function automatic logic [1:0] rand_op();
`ifdef LOGIC_ARB_OPSEL_EN
    return 2'($urandom_range(0, 3));
`else
    return 2'd0;
`endif
  endfunction

  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_req(input int i);
    ra[i] = 4'($urandom);
    rb[i] = 4'($urandom);
    ro[i] = rand_op();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    vld = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mptr = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) randomize_req(i);
    rst_n = 1'b0;
    vld = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 4'h0) begin failures++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vld = '0;
    drive_pt();
    rst_n = 1'b1;
    mptr = 0;
    drive_pt();
  endtask

  task automatic test_single();
    do_reset();
    ra[0] = 4'hC; rb[0] = 4'hA; ro[0] = 2'd0;
    vld = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    drive_pt();
    vld = '0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL single_ready_exec got=%b exp=0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    drive_pt();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", rsp_valid); end
    checks++; if (rsp_data !== 4'h8) begin failures++; $display("FAIL single_data got=%h exp=8", rsp_data); end
    checks++; if (rsp_id !== 2'd0) begin failures++; $display("FAIL single_id got=%0d exp=0", rsp_id); end
    rsp_ready = 1'b1;
    drive_pt();
    rsp_ready = 1'b0;
    mptr = 1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_done_valid got=%b exp=0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_done_busy got=%b exp=0", busy); end
    drive_pt();
  endtask

  task automatic test_all_valid();
    int exp;
    logic [3:0] ed;
    do_reset();
    for (int i = 0; i < 4; i++) randomize_req(i);
    vld = 4'hF;
    rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      exp = rr_pick(vld, mptr);
      @(negedge clk);
      checks++; if (req_ready !== 4'(1 << exp)) begin failures++; $display("FAIL all_ready n=%0d got=%b exp=%b", n, req_ready, 4'(1 << exp)); end
      ed = ref_fn(ra[exp], rb[exp], ro[exp]);
      drive_pt();
      randomize_req(exp);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL all_exec_valid n=%0d got=%b exp=0", n, rsp_valid); end
      drive_pt();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL all_valid n=%0d got=%b exp=1", n, rsp_valid); end
      checks++; if (rsp_id !== 2'(exp)) begin failures++; $display("FAIL all_id n=%0d got=%0d exp=%0d", n, rsp_id, exp); end
      checks++; if (rsp_data !== ed) begin failures++; $display("FAIL all_data n=%0d got=%h exp=%h", n, rsp_data, ed); end
      drive_pt();
      mptr = (exp + 1) % 4;
    end
    vld = '0;
    rsp_ready = 1'b0;
    drive_pt();
  endtask

  task automatic test_backpressure();
    int exp;
    logic [3:0] ed;
    for (int i = 0; i < 4; i++) randomize_req(i);
    vld = 4'($urandom_range(1, 15));
    exp = rr_pick(vld, mptr);
    @(negedge clk);
    checks++; if (req_ready !== 4'(1 << exp)) begin failures++; $display("FAIL bp_ready got=%b exp=%b", req_ready, 4'(1 << exp)); end
    ed = ref_fn(ra[exp], rb[exp], ro[exp]);
    drive_pt();
    drive_pt();
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_valid s=%0d got=%b exp=1", s, rsp_valid); end
      checks++; if (rsp_data !== ed) begin failures++; $display("FAIL bp_data s=%0d got=%h exp=%h", s, rsp_data, ed); end
      checks++; if (rsp_id !== 2'(exp)) begin failures++; $display("FAIL bp_id s=%0d got=%0d exp=%0d", s, rsp_id, exp); end
      checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL bp_req_ready s=%0d got=%b exp=0000", s, req_ready); end
      drive_pt();
    end
    rsp_ready = 1'b1;
    drive_pt();
    rsp_ready = 1'b0;
    vld = '0;
    mptr = (exp + 1) % 4;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", rsp_valid); end
    drive_pt();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int i = 0; i < 4; i++) randomize_req(i);
    rsp_ready = 1'b1;
    vld = 4'b0100;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL fair_first got=%b exp=0100", req_ready); end
    drive_pt();
    vld = '0;
    drive_pt();
    drive_pt();
    mptr = 3;
    vld = 4'b1100;
    @(negedge clk);
    checks++; if (req_ready !== 4'(1 << rr_pick(vld, mptr))) begin failures++; $display("FAIL fair_second got=%b exp=1000", req_ready); end
    drive_pt();
    vld = 4'b0100;
    drive_pt();
    drive_pt();
    mptr = 0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL fair_third got=%b exp=0100", req_ready); end
    drive_pt();
    vld = '0;
    drive_pt();
    drive_pt();
    mptr = 3;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    vld = 4'b0010;
    @(negedge clk);
    checks++; if (req_ready !== 4'(1 << rr_pick(vld, mptr))) begin failures++; $display("FAIL rmid_accept got=%b exp=0010", req_ready); end
    drive_pt();
    vld = '0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL rmid_ready got=%b exp=0000", req_ready); end
    drive_pt();
    rst_n = 1'b1;
    mptr = 0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_data !== 4'h0) begin failures++; $display("FAIL rmid_data got=%h exp=0", rsp_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    for (int s = 0; s < 4; s++) begin
      drive_pt();
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rmid_replay s=%0d got=%b exp=0", s, rsp_valid); end
    end
    rsp_ready = 1'b0;
    vld = 4'hF;
    #1;
    checks++; if (req_ready !== 4'(1 << rr_pick(vld, mptr))) begin failures++; $display("FAIL rmid_ptr got=%b exp=0001", req_ready); end
    vld = '0;
    drive_pt();
  endtask

  task automatic test_random();
    int exp;
    int stall;
    logic [3:0] ed;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) randomize_req(i);
      vld = 4'($urandom_range(0, 15));
      exp = rr_pick(vld, mptr);
      @(negedge clk);
      if (exp < 0) begin
        checks++; if (req_ready !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL rnd_idle t=%0d ready=%b busy=%b exp=0000/0", t, req_ready, busy); end
        drive_pt();
        continue;
      end
      checks++; if (req_ready !== 4'(1 << exp)) begin failures++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, req_ready, 4'(1 << exp)); end
      ed = ref_fn(ra[exp], rb[exp], ro[exp]);
      drive_pt();
      vld = '0;
      rsp_ready = 1'($urandom);
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rnd_exec t=%0d got=%b exp=0", t, rsp_valid); end
      drive_pt();
      stall = $urandom_range(0, 3);
      for (int s = 0; s <= stall; s++) begin
        rsp_ready = (s == stall);
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp) || rsp_data !== ed) begin failures++; $display("FAIL rnd_rsp t=%0d got=%b/%0d/%h exp=1/%0d/%h", t, rsp_valid, rsp_id, rsp_data, exp, ed); end
        drive_pt();
      end
      rsp_ready = 1'b0;
      mptr = (exp + 1) % 4;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rnd_done t=%0d got=%b exp=0", t, rsp_valid); end
      drive_pt();
    end
  endtask

`ifdef LOGIC_ARB_OPSEL_EN
  task automatic test_opsel();
    logic [3:0] exp_tbl [4];
    exp_tbl[1] = 4'hE; exp_tbl[2] = 4'h6; exp_tbl[3] = 4'h7;
    for (int o = 1; o < 4; o++) begin
      ra[mptr] = 4'hC; rb[mptr] = 4'hA; ro[mptr] = 2'(o);
      vld = 4'(1 << mptr);
      drive_pt();
      vld = '0;
      drive_pt();
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_tbl[o]) begin failures++; $display("FAIL opsel op=%0d got=%b/%h exp=1/%h", o, rsp_valid, rsp_data, exp_tbl[o]); end
      drive_pt();
      rsp_ready = 1'b0;
      mptr = (mptr + 1) % 4;
    end
    drive_pt();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_valid();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    test_random();
`ifdef LOGIC_ARB_OPSEL_EN
    test_opsel();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Round-robin controller that shares one registered 4-bit bitwise logic unit among NREQ requesters. Each requester presents operands with a valid/ready handshake. The arbiter grants one requester, launches the operation, and returns the result tagged with the requester index on a single response channel with backpressure. It sits between the core's small control agents and the shared bitwise datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, operand/result width in bits
- IDW, $clog2(NREQ), width of requester index (localparam)
- clk  input  1  single clock, all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept strobe (one-hot or zero)
- req_a  input  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  input  NREQ*WIDTH  operand B, same packing
- req_op  input  NREQ*2  opcode per requester (only with LOGIC_ARB_OPSEL_EN)
- rsp_valid  output  1  result valid
- rsp_ready  input  1  consumer accepts result
- rsp_data  output  WIDTH  result
- rsp_id  output  IDW  index of requester that produced rsp_data
- busy  output  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: the grant is the first i with req_valid[i], searching from ptr upward with wrap mod NREQ. req_ready[grant] is asserted combinationally in the same cycle. The rising edge captures a, b, op and id, then the FSM moves to EXEC. If no request is valid, the FSM stays in IDLE and req_ready is 0.
- req_ready is 0 in EXEC and RESP. A requester must hold valid and operands until it sees ready.
- EXEC: the datapath computes from the captured operands. The result registers into rsp_data and the FSM moves to RESP.
- RESP: rsp_valid is 1, and rsp_data and rsp_id are held stable. On rsp_valid && rsp_ready the FSM moves to IDLE and ptr becomes (id+1) mod NREQ. Otherwise the FSM stays in RESP.
- ptr advances only on response handshake, so there is no starvation.
- Opcode encoding: 00 AND, 01 OR, 10 XOR, 11 NAND.
- Reset (rst_n low at an edge, any state): FSM goes to IDLE, ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, captured registers cleared. Any in-flight result is discarded and not replayed.
- req_ready is 0 during any cycle in which rst_n is low.

## Timing
- Accept edge T: EXEC at T+1, rsp_valid high from T+2. Minimum latency is 2 cycles.
- Maximum throughput is one operation per 3 cycles (accept, exec, resp with rsp_ready=1).
- rsp_ready high on the cycle rsp_valid rises: handshake at that edge, and IDLE can accept a new request on the next cycle.
- Simultaneous valid from all requesters: grants proceed ptr, ptr+1, … in order.
- A request from the just-served requester is lowest priority in the next arbitration.
- rsp_ready while not RESP is ignored.
- All outputs are registered except req_ready (combinational from req_valid, ptr and state).

## Configuration
- LOGIC_ARB_OPSEL_EN defined: the req_op port exists. The 2-bit opcode is captured with the operands and the datapath implements all four ops.
- LOGIC_ARB_OPSEL_EN undefined: there is no req_op port, the datapath is AND only, and there is no opcode register. Timing and handshakes are identical.

## Structure
- Package logic_arb_pkg holds:
  - the state enum (IDLE/EXEC/RESP);
  - the opcode localparams (OP_AND, OP_OR, OP_XOR, OP_NAND);
  - the default WIDTH and NREQ.
- One sub-module, bitwise_unit: purely combinational WIDTH-bit logic unit (a, b, op → y). It is instantiated once and feeds the result register.
- Round-robin priority search stays inline, written as a loop over NREQ starting at ptr.

## Test plan
- Single request: req_valid=0001, a=4'hC, b=4'hA, op AND. Required: req_ready=0001 for one cycle, rsp_valid 2 cycles later, rsp_data=4'h8, rsp_id=0.
- All four valid continuously, rsp_ready=1. Required: rsp_id sequence 0,1,2,3,0, one response every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP. Required: rsp_valid, rsp_data and rsp_id are stable, req_ready=0 throughout, and the handshake completes on the edge where rsp_ready=1.
- Fairness: requester 2 is served, then requesters 2 and 3 are both valid. Required: 3 is granted before 2.
- Reset mid-operation: rst_n=0 during EXEC. Required: at the next edge rsp_valid=0, rsp_data=0, busy=0, ptr=0, and no response appears for the aborted request.
- With LOGIC_ARB_OPSEL_EN, a=4'hC, b=4'hA. Required: OR→4'hE, XOR→4'h6, NAND→4'h7.
